mod_n_serial_checker: RTL

//  Multi-channel serial divisibility checker for a compile-time divisor DIVISOR.

---
 rtl/mod_n_serial_checker.sv | 94 +++++++++
 1 files changed

// File: rtl/mod_n_serial_checker.sv
// Multi-channel streaming residue monitor: each channel folds a serial bit stream
// into its value mod DIVISOR (MSB-first or LSB-first) and flags exact divisibility.
module mod_n_serial_checker #(
  parameter int DIVISOR   = 3,
  parameter int CHANNELS  = 4,
  parameter int MSB_FIRST = 1,
  parameter int CNT_W     = 8
) (
  input  logic                                  clk,
  input  logic                                  resetn,
  input  logic [CHANNELS-1:0]                   din_valid,
  input  logic [CHANNELS-1:0]                   din,
  input  logic [CHANNELS-1:0]                   clear,
  output logic [CHANNELS-1:0]                   dout,
  output logic [CHANNELS*$clog2(DIVISOR)-1:0]   rem,
  output logic [CHANNELS-1:0]                   started,
  output logic [CHANNELS*CNT_W-1:0]             bit_cnt
);

  localparam int RW = $clog2(DIVISOR);
  localparam logic [RW:0]   DIV_W = (RW+1)'(DIVISOR);
  localparam logic [RW-1:0] W_ONE = RW'(1);

  if (DIVISOR < 2 || DIVISOR > 255) begin : g_bad_divisor
    $error("mod_n_serial_checker: DIVISOR must be in 2..255");
  end

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    logic [RW-1:0]    r_q, r_d;
    logic [RW-1:0]    w_q, w_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             started_q, started_d;
    logic             dout_q, dout_d;

    logic [RW-1:0]    base_r, base_w;
    logic [CNT_W-1:0] base_cnt;
    logic [RW:0]      t, s, u, t_red, s_red, u_red;

    // A bit arriving with clear starts a fresh value, so fold it onto idle state.
    always_comb begin
      base_r   = clear[i] ? '0 : r_q;
      base_w   = clear[i] ? W_ONE : w_q;
      base_cnt = clear[i] ? '0 : cnt_q;

      t     = {base_r, 1'b0} + {{RW{1'b0}}, din[i]};
      t_red = (t >= DIV_W) ? t - DIV_W : t;
      s     = {1'b0, base_r} + (din[i] ? {1'b0, base_w} : '0);
      s_red = (s >= DIV_W) ? s - DIV_W : s;
      u     = {base_w, 1'b0};
      u_red = (u >= DIV_W) ? u - DIV_W : u;

      r_d       = r_q;
      w_d       = w_q;
      cnt_d     = cnt_q;
      started_d = started_q;

      if (din_valid[i]) begin
        r_d       = (MSB_FIRST != 0) ? RW'(t_red) : RW'(s_red);
        w_d       = RW'(u_red);
        cnt_d     = (&base_cnt) ? base_cnt : base_cnt + 1'b1;
        started_d = 1'b1;
      end else if (clear[i]) begin
        r_d       = '0;
        w_d       = W_ONE;
        cnt_d     = '0;
        started_d = 1'b0;
      end

      dout_d = started_d & (r_d == '0);
    end

    always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
        r_q       <= '0;
        w_q       <= W_ONE;
        cnt_q     <= '0;
        started_q <= 1'b0;
        dout_q    <= 1'b0;
      end else begin
        r_q       <= r_d;
        w_q       <= w_d;
        cnt_q     <= cnt_d;
        started_q <= started_d;
        dout_q    <= dout_d;
      end
    end

    assign dout[i]                  = dout_q;
    assign rem[i*RW +: RW]          = r_q;
    assign started[i]               = started_q;
    assign bit_cnt[i*CNT_W +: CNT_W] = cnt_q;
  end

endmodule
